// File: rtl/ez8_pkg.sv
// Shared definitions for the ALU writeback slice: FSM encoding, accumulator
// reset default and the packed architectural context {accum, z, c}.
// Pure declarations; no timing or flow-control behaviour of its own.
package ez8_pkg;

  // Writeback FSM encoding (kept as plain constants for legacy tools)
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RF_WAIT = 1'b1;

  localparam logic [7:0] RESET_ACCUM_DEF = 8'h00;

  // 10-bit architectural context saved/restored around interrupts
  typedef struct packed {
    logic [7:0] accum;
    logic       z_flag;
    logic       c_flag;
  } ctx_t;

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-result / register-file / bypass bundle between ALU side and writeback.
// No latency of its own; pure wiring.
// Backpressure carried by in_ready (ALU side) and rf_ack (register-file side).
interface alu_writeback_if #(
  parameter int ADDR_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        result;
  logic              accum_write;
  logic              reg_write;
  logic              z_write;
  logic              c_write;
  logic              zout;
  logic              cout;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        accum;
  logic              z_flag;
  logic              c_flag;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [7:0]        rf_wdata;
  logic              rf_ack;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [7:0]        fwd_data;
  logic              ctx_save;
  logic              ctx_restore;

  // Environment side: ALU, register file and interrupt controller
  modport master (
    output in_valid, result, accum_write, reg_write, z_write, c_write,
           zout, cout, reg_addr, rf_ack, ctx_save, ctx_restore,
    input  in_ready, accum, z_flag, c_flag, rf_we, rf_waddr, rf_wdata,
           fwd_valid, fwd_addr, fwd_data
  );

  // Writeback block side
  modport slave (
    input  in_valid, result, accum_write, reg_write, z_write, c_write,
           zout, cout, reg_addr, rf_ack, ctx_save, ctx_restore,
    output in_ready, accum, z_flag, c_flag, rf_we, rf_waddr, rf_wdata,
           fwd_valid, fwd_addr, fwd_data
  );

endinterface

// File: rtl/alu_writeback_ctx_shadow.sv
// Shadow copy of {accum, z_flag, c_flag} for interrupt entry/exit.
// Save lands one cycle after the i_save pulse; o_ctx is the register output.
// No backpressure; a save coinciding with a restore is discarded.
module ctx_shadow
  import ez8_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_save,
  input  logic i_restore,
  input  ctx_t i_ctx,
  output ctx_t o_ctx
);

  ctx_t r_shadow;

  // Capture the context on a save pulse unless a restore is also requested
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
    end else if (i_save && !i_restore) begin
      r_shadow <= i_ctx;
    end
  end

  assign o_ctx = r_shadow;

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: updates accum/flags and issues one register-file write per reg_write.
// Accum/flags visible 1 cycle after handshake; rf_we asserted the cycle after handshake.
// in_ready drops while a register write is pending and returns in the rf_ack cycle.
module alu_writeback
  import ez8_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] RESET_ACCUM = RESET_ACCUM_DEF
) (
  input logic           clk,
  input logic           reset_n,
  alu_writeback_if.slave bus
);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wdata;
  ctx_t              r_ctx;

  logic              w_rf_busy;
  logic              w_in_ready;
  logic              w_hs;
  ctx_t              w_ctx_upd;
  ctx_t              w_ctx_shadow;
  ctx_t              w_ctx_next;

  assign w_rf_busy  = (r_state == ST_RF_WAIT);
  // Held low during reset; in RF_WAIT a new result is taken only in the ack cycle
  assign w_in_ready = reset_n && (!w_rf_busy || bus.rf_ack);
  assign w_hs       = bus.in_valid && w_in_ready;

  // Post-handshake context; a register write suppresses the accumulator update
  always_comb begin
    w_ctx_upd = r_ctx;
    if (w_hs) begin
      if (bus.accum_write && !bus.reg_write) w_ctx_upd.accum  = bus.result;
      if (bus.z_write)                       w_ctx_upd.z_flag = bus.zout;
      if (bus.c_write)                       w_ctx_upd.c_flag = bus.cout;
    end
  end

  // Restore overrides whatever the handshake would have written
  assign w_ctx_next = bus.ctx_restore ? w_ctx_shadow : w_ctx_upd;

  ctx_shadow u_ctx_shadow (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_save    (bus.ctx_save),
    .i_restore (bus.ctx_restore),
    .i_ctx     (w_ctx_upd),
    .o_ctx     (w_ctx_shadow)
  );

  // Architectural accumulator and flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctx.accum  <= RESET_ACCUM;
      r_ctx.z_flag <= 1'b0;
      r_ctx.c_flag <= 1'b0;
    end else begin
      r_ctx <= w_ctx_next;
    end
  end

  // Register-file write FSM; a new reg_write in the ack cycle chains without a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_hs && bus.reg_write) begin
      r_state <= ST_RF_WAIT;
      r_waddr <= bus.reg_addr;
      r_wdata <= bus.result;
    end else if (w_rf_busy && bus.rf_ack) begin
      r_state <= ST_IDLE;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.accum     = r_ctx.accum;
  assign bus.z_flag    = r_ctx.z_flag;
  assign bus.c_flag    = r_ctx.c_flag;
  assign bus.rf_we     = w_rf_busy;
  assign bus.rf_waddr  = r_waddr;
  assign bus.rf_wdata  = r_wdata;
  assign bus.fwd_valid = w_rf_busy;
  assign bus.fwd_addr  = r_waddr;
  assign bus.fwd_data  = r_wdata;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: hand-computed vectors checked with immediate assertions.
// Inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
// Covers reset, flag/accum updates, rf backpressure, back-to-back writes, context save/restore.
module tb_alu_writeback;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  alu_writeback_if #(.ADDR_W(8)) bus ();

  alu_writeback #(.ADDR_W(8), .RESET_ACCUM(8'h00)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.in_valid    = 1'b0;
    bus.result      = 8'h00;
    bus.accum_write = 1'b0;
    bus.reg_write   = 1'b0;
    bus.z_write     = 1'b0;
    bus.c_write     = 1'b0;
    bus.zout        = 1'b0;
    bus.cout        = 1'b0;
    bus.reg_addr    = 8'h00;
    bus.rf_ack      = 1'b0;
    bus.ctx_save    = 1'b0;
    bus.ctx_restore = 1'b0;
  endtask

  task automatic acc_op(input logic [7:0] res, input logic cw, input logic co);
    bus.in_valid    = 1'b1;
    bus.result      = res;
    bus.accum_write = 1'b1;
    bus.c_write     = cw;
    bus.cout        = co;
  endtask

  task automatic reg_op(input logic [7:0] addr, input logic [7:0] data);
    bus.in_valid  = 1'b1;
    bus.reg_write = 1'b1;
    bus.reg_addr  = addr;
    bus.result    = data;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    clr();

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_rf_we",    bus.rf_we,    0);
    chk("rst_accum",    bus.accum,    8'h00);
    chk("rst_z",        bus.z_flag,   0);
    chk("rst_c",        bus.c_flag,   0);
    chk("rst_waddr",    bus.rf_waddr, 0);
    chk("rst_wdata",    bus.rf_wdata, 0);
    #2 reset_n = 1'b1;
    tick();
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Accum + carry load
    acc_op(8'h5A, 1'b1, 1'b1);
    tick(); clr(); #1;
    chk("ld_accum", bus.accum,  8'h5A);
    chk("ld_c",     bus.c_flag, 1);
    chk("ld_z",     bus.z_flag, 0);

    // Zero result with z_write; carry untouched
    acc_op(8'h00, 1'b0, 1'b0);
    bus.z_write = 1'b1;
    bus.zout    = 1'b1;
    tick(); clr(); #1;
    chk("zero_accum", bus.accum,  8'h00);
    chk("zero_z",     bus.z_flag, 1);
    chk("zero_c",     bus.c_flag, 1);
    chk("zero_rf_we", bus.rf_we,  0);

    // Register write held through three cycles of no ack
    reg_op(8'd5, 8'hA5);
    tick(); clr(); #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) acc_op(8'h77, 1'b0, 1'b0);
      #1;
      chk("hold_rf_we",     bus.rf_we,     1);
      chk("hold_waddr",     bus.rf_waddr,  8'd5);
      chk("hold_wdata",     bus.rf_wdata,  8'hA5);
      chk("hold_in_ready",  bus.in_ready,  0);
      chk("hold_fwd_valid", bus.fwd_valid, 1);
      chk("hold_fwd_data",  bus.fwd_data,  8'hA5);
      tick(); clr();
    end
    chk("blocked_accum", bus.accum, 8'h00);
    bus.rf_ack = 1'b1;
    #1;
    chk("ack_rf_we",    bus.rf_we,    1);
    chk("ack_in_ready", bus.in_ready, 1);
    tick(); clr(); #1;
    chk("after_ack_rf_we", bus.rf_we, 0);

    // Back-to-back register writes
    reg_op(8'd5, 8'hA5);
    tick(); clr();
    bus.rf_ack = 1'b1;
    reg_op(8'd6, 8'h3C);
    #1;
    chk("b2b_first_addr", bus.rf_waddr, 8'd5);
    chk("b2b_in_ready",   bus.in_ready, 1);
    tick(); clr(); #1;
    chk("b2b_rf_we",  bus.rf_we,    1);
    chk("b2b_waddr",  bus.rf_waddr, 8'd6);
    chk("b2b_wdata",  bus.rf_wdata, 8'h3C);
    bus.rf_ack = 1'b1;
    tick(); clr(); #1;
    chk("b2b_done_rf_we", bus.rf_we, 0);

    // reg_write wins over accum_write
    reg_op(8'd7, 8'h99);
    bus.accum_write = 1'b1;
    tick(); clr(); #1;
    chk("rw_accum", bus.accum,    8'h00);
    chk("rw_rf_we", bus.rf_we,    1);
    chk("rw_waddr", bus.rf_waddr, 8'd7);
    chk("rw_wdata", bus.rf_wdata, 8'h99);
    bus.rf_ack = 1'b1;
    tick(); clr(); #1;

    // Context save / restore
    acc_op(8'h12, 1'b1, 1'b1);
    tick(); clr();
    bus.ctx_save = 1'b1;
    tick(); clr();
    acc_op(8'hFF, 1'b1, 1'b0);
    tick(); clr(); #1;
    chk("mod_accum", bus.accum,  8'hFF);
    chk("mod_c",     bus.c_flag, 0);
    bus.ctx_restore = 1'b1;
    acc_op(8'h33, 1'b0, 1'b0);
    tick(); clr(); #1;
    chk("rest_accum", bus.accum,  8'h12);
    chk("rest_c",     bus.c_flag, 1);
    chk("rest_z",     bus.z_flag, 1);

    // Save takes post-handshake values
    acc_op(8'h44, 1'b0, 1'b0);
    bus.ctx_save = 1'b1;
    tick(); clr();
    acc_op(8'h55, 1'b0, 1'b0);
    tick(); clr();
    bus.ctx_save    = 1'b1;
    bus.ctx_restore = 1'b1;
    tick(); clr(); #1;
    chk("save_rest_accum", bus.accum, 8'h44);
    acc_op(8'h66, 1'b0, 1'b0);
    tick(); clr();
    bus.ctx_restore = 1'b1;
    tick(); clr(); #1;
    chk("shadow_kept", bus.accum, 8'h44);

    // Reset while a register write is pending
    reg_op(8'd9, 8'hC3);
    tick(); clr(); #1;
    chk("pre_rst_rf_we", bus.rf_we, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rf_we",    bus.rf_we,    0);
    chk("mid_rst_accum",    bus.accum,    8'h00);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_waddr",    bus.rf_waddr, 0);
    tick();
    #2 reset_n = 1'b1;
    tick(); #1;
    chk("post_rst2_rf_we",    bus.rf_we,    0);
    chk("post_rst2_in_ready", bus.in_ready, 1);
    tick(); #1;
    chk("no_late_write", bus.rf_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, register-file address width.
REQ-002 SHALL have parameter RESET_ACCUM, default 8'h00, accumulator reset value.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  ALU outputs below are valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts an ALU result this cycle.
REQ-007 SHALL have port result  input  8  ALU result.
REQ-008 SHALL have ports accum_write, reg_write, z_write, c_write  input  1 each  ALU write strobes.
REQ-009 SHALL have ports zout, cout  input  1 each  ALU flag values.
REQ-010 SHALL have port reg_addr  input  ADDR_W  destination register for reg_write.
REQ-011 SHALL have port accum  output  8  accumulator register (ALU accum operand).
REQ-012 SHALL have ports z_flag, c_flag  output  1 each  status flags (c_flag is ALU cin).
REQ-013 SHALL have ports rf_we, rf_waddr (ADDR_W), rf_wdata (8)  output  register-file write request.
REQ-014 SHALL have port rf_ack  input  1  register file accepted the write this cycle.
REQ-015 SHALL have ports fwd_valid (1), fwd_addr (ADDR_W), fwd_data (8)  output  pending write, for operand bypass.
REQ-016 SHALL have ports ctx_save, ctx_restore  input  1 each  interrupt entry/exit pulses.

Function
REQ-017 SHALL accept a transfer when in_valid && in_ready (handshake cycle).
REQ-018 SHALL, on handshake, load accum<=result if accum_write, z_flag<=zout if z_write, c_flag<=cout if c_write; visible next cycle (1-cycle latency).
REQ-019 SHALL, on handshake with reg_write=1, capture reg_addr/result and enter state RF_WAIT; else stay IDLE.
REQ-020 SHALL drive in_ready=1 in IDLE; in RF_WAIT in_ready=rf_ack (accept new transfer in the ack cycle).
REQ-021 SHALL in RF_WAIT hold rf_we=1, rf_waddr/rf_wdata stable until rf_ack; rf_we=0 in IDLE.
REQ-022 SHALL, on rf_ack with simultaneous handshake carrying reg_write, stay RF_WAIT with the new address/data (back-to-back, no bubble).
REQ-023 SHALL, on rf_ack without new reg_write handshake, return to IDLE.
REQ-024 SHALL drive fwd_valid=rf_we, fwd_addr=rf_waddr, fwd_data=rf_wdata combinationally.
REQ-025 SHALL ignore accum_write if reg_write also set (reg_write wins; accum unchanged).
REQ-026 SHALL on ctx_save copy {accum,z_flag,c_flag} into shadow registers, taking post-handshake values if both occur in the same cycle.
REQ-027 SHALL on ctx_restore load {accum,z_flag,c_flag} from shadow, overriding any same-cycle handshake update; pending RF_WAIT write unaffected.
REQ-028 SHALL treat ctx_save && ctx_restore together as restore only.
REQ-029 SHALL never drop or duplicate a register write: exactly one rf_we..rf_ack window per accepted reg_write.

Reset
REQ-030 SHALL on reset_n low immediately force: state IDLE, accum=RESET_ACCUM, z_flag=0, c_flag=0, shadows=0, rf_we=0, rf_waddr=0, rf_wdata=0, in_ready=0 while reset asserted.
REQ-031 SHALL abandon any pending RF_WAIT write on reset mid-operation.
REQ-032 SHALL deassert reset cleanly: in_ready=1 on first cycle after reset_n rises.

Structure
REQ-033 SHALL place state encoding (IDLE=0, RF_WAIT=1) and RESET_ACCUM default in shared package ez8_pkg.
REQ-034 SHALL implement the shadow context as sub-module ctx_shadow (10-bit save/restore register).

Verification
REQ-035 SHALL test: handshake result=8'h00, accum_write=1, z_write=1, zout=1 -> next cycle accum=00, z_flag=1, rf_we=0.
REQ-036 SHALL test: reg_write to addr 5, data 8'hA5, rf_ack low 3 cycles -> rf_we held 4 cycles with 5/A5, in_ready=0 until ack cycle.
REQ-037 SHALL test: back-to-back reg_write (5,A5) then (6,3C) with rf_ack on cycle 1 -> rf_waddr 5 then 6 with no idle cycle.
REQ-038 SHALL test: accum=12, c_flag=1, ctx_save; then update accum=FF, c_flag=0; ctx_restore -> accum=12, c_flag=1.
REQ-039 SHALL test: reset_n asserted during RF_WAIT -> rf_we=0 immediately, accum=RESET_ACCUM, no later write.
REQ-040 SHALL test: reg_write && accum_write on same handshake -> accum unchanged, register write issued.
